// File: rtl/axi_pkg.sv
// Shared AXI field widths and the read-arbiter state encoding, used by the
// read arbiter today and intended for a matching write arbiter later.
package axi_pkg;

  localparam int AXI_ID_W   = 16;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_RESP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod N.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      // one extra bit so ptr+i never overflows before the wrap subtract
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port among NREQ requesters: round-robin AR grant, one
// burst in flight, arid tags the owner and R beats are steered back to it.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_arvalid,
  output logic [NREQ-1:0]            req_arready,
  input  logic [NREQ*AXI_ADDR_W-1:0] req_araddr,
  input  logic [NREQ*AXI_LEN_W-1:0]  req_arlen,
  input  logic [NREQ*AXI_SIZE_W-1:0] req_arsize,
  output logic [NREQ-1:0]            req_rvalid,
  input  logic [NREQ-1:0]            req_rready,
  output logic [AXI_DATA_W-1:0]      req_rdata,
  output logic [AXI_RESP_W-1:0]      req_rresp,
  output logic                       req_rlast,
  output logic [AXI_ID_W-1:0]        m_arid,
  output logic [AXI_ADDR_W-1:0]      m_araddr,
  output logic [AXI_LEN_W-1:0]       m_arlen,
  output logic [AXI_SIZE_W-1:0]      m_arsize,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [AXI_ID_W-1:0]        m_rid,
  input  logic [AXI_DATA_W-1:0]      m_rdata,
  input  logic [AXI_RESP_W-1:0]      m_rresp,
  input  logic                       m_rlast,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  output logic                       err
);

  rd_state_e             state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic [AXI_LEN_W-1:0]  beat;

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;

  logic [AXI_ADDR_W-1:0] sel_addr;
  logic [AXI_LEN_W-1:0]  sel_len;
  logic [AXI_SIZE_W-1:0] sel_size;

  logic [AXI_ADDR_W-1:0] ar_addr_p0;
  logic [AXI_LEN_W-1:0]  ar_len_p0;
  logic [AXI_SIZE_W-1:0] ar_size_p0;

  logic                  in_data;
  logic                  r_hs;
  logic                  rid_bad;
  logic                  last_bad;

  // Arbitration is only offered while idle, so the grant is a single pulse.
  assign arb_req = (state == ST_IDLE) ? req_arvalid : '0;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_arready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
        sel_len  = sel_len  | req_arlen[i*AXI_LEN_W +: AXI_LEN_W];
        sel_size = sel_size | req_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
      end
    end
  end

  assign in_data  = (state == ST_DATA);
  assign m_rready = in_data & req_rready[owner];
  assign r_hs     = m_rvalid & m_rready;
  assign rid_bad  = (m_rid != {{(AXI_ID_W-IW){1'b0}}, owner});
  assign last_bad = (m_rlast != (beat == ar_len_p0));

  always_comb begin
    req_rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rvalid[i] = in_data & m_rvalid & (owner == IW'(i));
    end
  end

  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

  assign m_arid   = {{(AXI_ID_W-IW){1'b0}}, owner};
  assign m_araddr = ar_addr_p0;
  assign m_arlen  = ar_len_p0;
  assign m_arsize = ar_size_p0;

  // ---- stage p0: AR payload captured at grant, held through ADDR/DATA ----
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gnt_any) begin
      ar_addr_p0 <= sel_addr;
      ar_len_p0  <= sel_len;
      ar_size_p0 <= sel_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      beat      <= '0;
      m_arvalid <= 1'b0;
      err       <= 1'b0;
    end else begin
      // R traffic while no burst is accepting data is a protocol violation
      if (m_rvalid && !in_data) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_idx;
            ptr       <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            beat      <= '0;
            m_arvalid <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat <= beat + 1'b1;
            if (rid_bad || last_bad) err <= 1'b1;
            // the emulator's rlast is authoritative for ending the burst
            if (m_rlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with NREQ=3 and a hand-driven emulator.
module tb_axi_rd_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_arvalid;
  logic [2:0]    req_arready;
  logic [191:0]  req_araddr;
  logic [23:0]   req_arlen;
  logic [8:0]    req_arsize;
  logic [2:0]    req_rvalid;
  logic [2:0]    req_rready;
  logic [511:0]  req_rdata;
  logic [1:0]    req_rresp;
  logic          req_rlast;
  logic [15:0]   m_arid;
  logic [63:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic          m_arvalid;
  logic          m_arready;
  logic [15:0]   m_rid;
  logic [511:0]  m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rvalid;
  logic          m_rready;
  logic          err;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter #(.NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0;
    req_rready = '0; m_arready = 1'b0; m_rid = '0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] s);
    req_araddr[i*64 +: 64] = a;
    req_arlen[i*8 +: 8]    = l;
    req_arsize[i*3 +: 3]   = s;
    req_arvalid[i]         = 1'b1;
  endtask

  // Waits (bounded) for a grant, returns it, then lets the DUT latch it and
  // drops the granted requester's valid. g==0 means the wait expired.
  task automatic get_grant(output logic [2:0] g);
    g = '0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (req_arready != 3'b000) begin
        g = req_arready;
        break;
      end
      tick;
    end
    if (g != 3'b000) begin
      tick;
      req_arvalid = req_arvalid & ~g;
    end
  endtask

  task automatic ar_accept;
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b want=0", m_arvalid); end
    checks++; if (req_arready !== 3'b000) begin errors++; $display("FAIL reset_arready got=%b want=000", req_arready); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b want=0", m_rready); end
    checks++; if (req_rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got=%b want=000", req_rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_single;
    logic [2:0] g;
    set_req(0, 64'h40, 8'd0, 3'd6);
    get_grant(g);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL single_grant got=%b want=001", g); end
    checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got=%b want=1", m_arvalid); end
    checks++; if (m_arid !== 16'd0) begin errors++; $display("FAIL single_arid got=%0h want=0", m_arid); end
    checks++; if (m_araddr !== 64'h40) begin errors++; $display("FAIL single_araddr got=%0h want=40", m_araddr); end
    ar_accept;
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop got=%b want=0", m_arvalid); end
    req_rready = 3'b001; m_rid = 16'd0; m_rlast = 1'b1; m_rvalid = 1'b1;
    m_rdata = 512'h1234_5678; m_rresp = 2'b01;
    #1;
    checks++; if (req_rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid got=%b want=001", req_rvalid); end
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL single_rready got=%b want=1", m_rready); end
    checks++; if (req_rdata[31:0] !== 32'h1234_5678 || req_rresp !== 2'b01 || req_rlast !== 1'b1) begin
      errors++; $display("FAIL single_payload got=%0h/%b/%b want=12345678/01/1", req_rdata[31:0], req_rresp, req_rlast); end
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    #1;
    checks++; if (m_rready !== 1'b0 || req_rvalid !== 3'b000) begin
      errors++; $display("FAIL single_idle got=%b/%b want=0/000", m_rready, req_rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b want=0", err); end
  endtask

  task automatic test_round_robin;
    logic [2:0] g;
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    do_reset;
    for (int i = 0; i < 3; i++) set_req(i, 64'h1000 * (i + 1), 8'd0, 3'd6);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) for (int i = 0; i < 3; i++) set_req(i, 64'h1000 * (i + 1), 8'd0, 3'd6);
      get_grant(g);
      checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d got=%b want=%b", k, g, exp_g[k]); end
      checks++; if (m_arid !== 16'(k % 3)) begin errors++; $display("FAIL rr_arid%0d got=%0d want=%0d", k, m_arid, k % 3); end
      checks++; if (m_araddr !== 64'h1000 * ((k % 3) + 1)) begin
        errors++; $display("FAIL rr_araddr%0d got=%0h want=%0h", k, m_araddr, 64'h1000 * ((k % 3) + 1)); end
      ar_accept;
      req_rready = 3'b111; m_rid = 16'(k % 3); m_rlast = 1'b1; m_rvalid = 1'b1;
      #1;
      checks++; if (req_rvalid !== exp_g[k]) begin errors++; $display("FAIL rr_route%0d got=%b want=%b", k, req_rvalid, exp_g[k]); end
      tick;
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
    req_arvalid = '0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err got=%b want=0", err); end
  endtask

  task automatic test_rready_backpressure;
    logic [2:0] g;
    int k;
    set_req(1, 64'h2000, 8'd3, 3'd6);
    get_grant(g);
    checks++; if (g !== 3'b010) begin errors++; $display("FAIL bp_grant got=%b want=010", g); end
    ar_accept;
    k = 0;
    m_rid = 16'd1;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      req_rready = (cyc % 2 == 0) ? 3'b010 : 3'b000;
      m_rvalid = 1'b1;
      m_rdata = 512'(64'h2000 + 64 * k);
      m_rlast = (k == 3);
      #1;
      checks++; if (m_rready !== req_rready[1]) begin
        errors++; $display("FAIL bp_mirror%0d got=%b want=%b", cyc, m_rready, req_rready[1]); end
      checks++; if (req_rvalid !== 3'b010) begin errors++; $display("FAIL bp_rvalid%0d got=%b want=010", cyc, req_rvalid); end
      if (req_rready[1]) begin
        checks++; if (req_rdata[63:0] !== 64'h2000 + 64 * k) begin
          errors++; $display("FAIL bp_data%0d got=%0h want=%0h", k, req_rdata[63:0], 64'h2000 + 64 * k); end
        k++;
      end
      tick;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '0;
    #1;
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_beats got=%0d want=4", k); end
    checks++; if (m_rready !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL bp_end got=%b/%b want=0/0", m_rready, err); end
  endtask

  task automatic test_ar_stall;
    logic [2:0] g;
    set_req(0, 64'hABCD_0000, 8'd5, 3'd3);
    get_grant(g);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL stall_grant got=%b want=001", g); end
    req_araddr[63:0] = 64'hDEAD; req_arlen[7:0] = 8'd9; req_arsize[2:0] = 3'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 64'hABCD_0000 || m_arlen !== 8'd5 ||
                    m_arsize !== 3'd3 || m_arid !== 16'd0) begin
        errors++; $display("FAIL stall_hold%0d got=%b/%0h/%0d/%0d/%0d want=1/abcd0000/5/3/0",
                           c, m_arvalid, m_araddr, m_arlen, m_arsize, m_arid); end
      tick;
    end
    ar_accept;
    req_rready = 3'b001; m_rid = 16'd0;
    for (int b = 0; b < 6; b++) begin
      m_rvalid = 1'b1; m_rlast = (b == 5);
      tick;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || m_rready !== 1'b0) begin
      errors++; $display("FAIL stall_end got=%b/%b want=0/0", err, m_rready); end
  endtask

  task automatic test_errors;
    logic [2:0] g;
    do_reset;
    set_req(1, 64'h3000, 8'd0, 3'd6);
    get_grant(g);
    ar_accept;
    req_rready = 3'b010; m_rid = 16'd2; m_rlast = 1'b1; m_rvalid = 1'b1;
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rid got=%b want=1", err); end
    do_reset;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
    set_req(1, 64'h4000, 8'd3, 3'd6);
    get_grant(g);
    ar_accept;
    req_rready = 3'b010; m_rid = 16'd1; m_rlast = 1'b0; m_rvalid = 1'b1;
    tick;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_beat0 got=%b want=0", err); end
    m_rlast = 1'b1;
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_early_last got=%b want=1", err); end
    req_arvalid = 3'b001;
    #1;
    checks++; if (req_arready !== 3'b001) begin errors++; $display("FAIL err_burst_end got=%b want=001", req_arready); end
    req_arvalid = '0;
  endtask

  task automatic test_reset_mid_burst;
    logic [2:0] g;
    do_reset;
    set_req(0, 64'h5000, 8'd7, 3'd6);
    get_grant(g);
    ar_accept;
    req_rready = 3'b001; m_rid = 16'd0; m_rlast = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1;
      tick;
    end
    m_rvalid = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0; m_rvalid = 1'b0; req_rready = '0;
    #1;
    checks++; if (m_arvalid !== 1'b0 || req_arready !== 3'b000 || m_rready !== 1'b0 ||
                  req_rvalid !== 3'b000 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid got=%b/%b/%b/%b/%b want=0/000/0/000/0",
                         m_arvalid, req_arready, m_rready, req_rvalid, err); end
    set_req(0, 64'h6000, 8'd0, 3'd6);
    set_req(2, 64'h7000, 8'd0, 3'd6);
    get_grant(g);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL rst_ptr got=%b want=001", g); end
    ar_accept;
    req_rready = 3'b111; m_rid = 16'd0; m_rlast = 1'b1; m_rvalid = 1'b1;
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    get_grant(g);
    checks++; if (g !== 3'b100 || m_arid !== 16'd2 || m_araddr !== 64'h7000) begin
      errors++; $display("FAIL rst_req2 got=%b/%0d/%0h want=100/2/7000", g, m_arid, m_araddr); end
    ar_accept;
    m_rid = 16'd2; m_rlast = 1'b1; m_rvalid = 1'b1;
    #1;
    checks++; if (req_rvalid !== 3'b100) begin errors++; $display("FAIL rst_req2_route got=%b want=100", req_rvalid); end
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_req2_err got=%b want=0", err); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_rready_backpressure;
    test_ar_stall;
    test_errors;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
